uart_tx: RTL and testbench
==========================

# uart_tx

UART serializer for the transmit side of the UART link. It accepts a parallel word through a valid pulse and shifts out one frame on `tx_out`: start bit, DWIDTH data bits LSB first, an optional parity bit, then a stop bit. Each bit is held for `prescale` clock cycles. The bit period therefore matches the oversampling ratio the receive path uses on the same `clk`, so TX and RX can be looped back directly.

## Interface
- DWIDTH, 8, data word width.
- PWIDTH, 6, prescale width. Legal prescale values are 1..2^PWIDTH-1.

- clk  input  1  single system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- p_data  input  DWIDTH  parallel word to transmit.
- data_valid  input  1  request strobe; sampled only when idle.
- par_en  input  1  1 = insert a parity bit.
- par_typ  input  1  0 = even parity, 1 = odd parity.
- prescale  input  PWIDTH  clock cycles per bit; 0 is treated as 1.
- tx_out  output  1  serial line; registered; idles high.
- busy  output  1  registered; high while a frame is in flight.

## Operation
- **States:** IDLE, START, DATA, PARITY, STOP.
- **IDLE:** tx_out=1, busy=0. If data_valid=1 at a rising edge, the following are latched at that edge:
  - p_data into a shift register;
  - par_en and par_typ;
  - prescale, with 0 replaced by 1.
  - The block then enters START.
- **START:** tx_out=0 for P cycles (P is the latched prescale), then goes to DATA.
- **DATA:** transmits bit 0 first, then bit 1, up to bit DWIDTH-1. Each bit is held P cycles.
  - The bit counter runs 0..DWIDTH-1.
  - After the last bit: go to PARITY if par_en=1, else STOP.
- **PARITY:** P cycles.
  - tx_out = XOR of the latched data bits when par_typ=0.
  - tx_out = its inverse when par_typ=1.
- **STOP:** tx_out=1 for P cycles, then return to IDLE.
- **Edge counter:** counts 0..P-1 and wraps to 0 on each bit boundary. The state or bit advances when the count equals P-1. It is held at 0 in IDLE.
- **Latching rule:** p_data, par_en, par_typ and prescale are ignored while busy=1. Changing them mid-frame has no effect on the current frame.
- **Parity:** computed from the latched word, never from live p_data.

## Timing
- **Reset:** while rst=1, regardless of clk:
  - tx_out=1, busy=0;
  - state=IDLE;
  - edge counter, bit counter and shift register = 0.
  - A reset asserted mid-frame aborts the frame immediately; the line returns high without a stop bit.
- **Acceptance:** data_valid=1 sampled at edge N in IDLE. From edge N, tx_out=0 (start bit) and busy=1.
- **Frame length:** L = P × (DWIDTH + 2 + par_en) cycles.
  - tx_out returns to 1 for the stop bit at edge N + P × (DWIDTH + 1 + par_en).
  - busy falls at edge N+L, when the state returns to IDLE.
- **Back-to-back:** data_valid held high continuously is accepted again at edge N+L+1. The line shows one idle-high cycle between frames.
- **Latency:** no cycle of latency between acceptance and the start bit. Each bit lasts exactly P cycles; there is no drift across the frame.
- **P=1:** one bit per clock. The frame is DWIDTH+2+par_en cycles long.
- **data_valid while busy:** has no effect and is not queued.

## Test plan
- **Basic frame:** p_data=0xA5, par_en=0, prescale=8, one-cycle data_valid. Required: tx_out shows 0,1,0,1,0,0,1,0,1,1, each bit exactly 8 cycles; busy high for 80 cycles; tx_out=1 afterwards.
- **Parity:** p_data=0xA5, par_en=1, prescale=4.
  - par_typ=0: parity bit 0.
  - par_typ=1: parity bit 1.
  - busy lasts 44 cycles in each case.
  - Repeat with 0x07: even parity 1, odd parity 0.
- **Ignore while busy:** pulse data_valid with p_data=0xFF at cycle 20 of an in-flight 0x00 frame (prescale=8). Required: the frame still carries 0x00; no second frame follows.
- **Back-to-back and prescale edges:** hold data_valid high with 0x3C then 0xC3.
  - Required: two complete frames separated by exactly one idle-high cycle.
  - Repeat with prescale=1: 10-cycle frames.
  - Repeat with prescale=0: behaves identically to prescale=1.
- **Reset mid-frame:** assert rst during data bit 3 of a prescale=8 frame. Required: tx_out=1 and busy=0 immediately, without waiting for a clock edge. After release, a new 0x5A request produces a clean full frame.
- **Loopback:** connect tx_out to the UART receive path at prescale=8 and send 256 random words with random parity settings. Required: every word is recovered with no parity or stop error.

Source files
------------

// File: rtl/uart_tx.sv
// UART transmit serializer: start bit, DWIDTH data bits LSB first, optional
// parity bit, stop bit; every bit is held for the latched prescale count.
module uart_tx #(
  parameter int DWIDTH = 8,
  parameter int PWIDTH = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DWIDTH-1:0] p_data,
  input  logic              data_valid,
  input  logic              par_en,
  input  logic              par_typ,
  input  logic [PWIDTH-1:0] prescale,
  output logic              tx_out,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  localparam int BW = (DWIDTH > 1) ? $clog2(DWIDTH) : 1;

  // Handshake: a request is data_valid=1 at a rising edge while busy=0; it is
  // accepted in that same edge. There is no ready; requests while busy are dropped.

  logic [2:0]        state;
  logic [PWIDTH-1:0] cnt;
  logic [PWIDTH-1:0] p_lat;
  logic [BW-1:0]     bit_cnt;
  logic [DWIDTH-1:0] shift;
  logic              par_on;
  logic              par_bit;
  logic              last;

  assign last      = (cnt == p_lat - PWIDTH'(1));
  assign dbg_state = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      p_lat   <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      par_on  <= 1'b0;
      par_bit <= 1'b0;
      tx_out  <= 1'b1;
      busy    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_cnt <= '0;
          tx_out  <= 1'b1;
          busy    <= 1'b0;
          if (data_valid) begin
            shift   <= p_data;
            par_on  <= par_en;
            // Parity of the word being latched; the shift register is consumed later.
            par_bit <= (^p_data) ^ par_typ;
            p_lat   <= (prescale == '0) ? PWIDTH'(1) : prescale;
            state   <= START;
            tx_out  <= 1'b0;
            busy    <= 1'b1;
          end
        end
        START: begin
          if (last) begin
            cnt    <= '0;
            state  <= DATA;
            tx_out <= shift[0];
          end else begin
            cnt <= cnt + PWIDTH'(1);
          end
        end
        DATA: begin
          if (last) begin
            cnt <= '0;
            if (bit_cnt == BW'(DWIDTH - 1)) begin
              if (par_on) begin
                state  <= PARITY;
                tx_out <= par_bit;
              end else begin
                state  <= STOP;
                tx_out <= 1'b1;
              end
            end else begin
              bit_cnt <= bit_cnt + BW'(1);
              shift   <= shift >> 1;
              tx_out  <= shift[1];
            end
          end else begin
            cnt <= cnt + PWIDTH'(1);
          end
        end
        PARITY: begin
          if (last) begin
            cnt    <= '0;
            state  <= STOP;
            tx_out <= 1'b1;
          end else begin
            cnt <= cnt + PWIDTH'(1);
          end
        end
        STOP: begin
          if (last) begin
            cnt    <= '0;
            state  <= IDLE;
            busy   <= 1'b0;
            tx_out <= 1'b1;
          end else begin
            cnt <= cnt + PWIDTH'(1);
          end
        end
        default: begin
          state  <= IDLE;
          cnt    <= '0;
          tx_out <= 1'b1;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: frames are predicted as a per-cycle line image built from
// the frame format, plus a sampling receiver for the loopback run.
module tb_uart_tx;
  localparam int DW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] p_data;
  logic          data_valid;
  logic          par_en;
  logic          par_typ;
  logic [PW-1:0] prescale;
  logic          tx_out;
  logic          busy;
  logic [2:0]    dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] exp_q[$];
  logic          exp_line[$];
  logic          obs_line[$];
  logic          obs_busy[$];

  uart_tx #(.DWIDTH(DW), .PWIDTH(PW)) dut (
    .clk(clk), .rst(rst), .p_data(p_data), .data_valid(data_valid),
    .par_en(par_en), .par_typ(par_typ), .prescale(prescale),
    .tx_out(tx_out), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Expected line, one entry per clock cycle of the frame.
  task automatic build_frame(input logic [DW-1:0] w, input bit pe, input bit pt, input int p);
    int pp;
    logic bits[$];
    pp = (p == 0) ? 1 : p;
    exp_line.delete();
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(w[i]);
    if (pe) bits.push_back(logic'(($countones(w) % 2) == 1) ^ logic'(pt));
    bits.push_back(1'b1);
    foreach (bits[i]) for (int r = 0; r < pp; r++) exp_line.push_back(bits[i]);
  endtask

  // Index of the first cycle where the captured line/busy differs from the
  // prediction (busy high during the frame, idle-high cycle right after), or -1.
  function automatic int first_diff();
    int n;
    n = exp_line.size();
    if (obs_line.size() < n + 1) return 0;
    for (int k = 0; k < n; k++)
      if (obs_line[k] !== exp_line[k] || obs_busy[k] !== 1'b1) return k;
    if (obs_line[n] !== 1'b1 || obs_busy[n] !== 1'b0) return n;
    return -1;
  endfunction

  // ---------------- drivers ----------------
  task automatic drive_req(input logic [DW-1:0] w, input bit pe, input bit pt, input int p, input bit hold);
    @(negedge clk);
    p_data     = w;
    par_en     = pe;
    par_typ    = pt;
    prescale   = PW'(p);
    data_valid = 1'b1;
    @(posedge clk);
    if (!hold) begin
      #1;
      data_valid = 1'b0;
    end
  endtask

  // Samples n cycles starting at the negedge after acceptance; optionally
  // fires a conflicting request at cycle 'poke'.
  task automatic capture(input int n, input int poke);
    obs_line.delete();
    obs_busy.delete();
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      obs_line.push_back(tx_out);
      obs_busy.push_back(busy);
      if (k == poke) begin
        p_data = 8'hFF; par_en = 1'b1; par_typ = 1'b1; prescale = 6'd3; data_valid = 1'b1;
      end else if (poke >= 0 && k == poke + 1) begin
        data_valid = 1'b0;
      end
    end
  endtask

  task automatic report_frame(input string name);
    int d;
    d = first_diff();
    n_tests++;
    if (d != -1) begin
      n_fail++;
      if (d < obs_line.size())
        $display("FAIL %s: cycle %0d tx_out=%b busy=%b, required tx_out=%b busy=%b",
                 name, d, obs_line[d], obs_busy[d],
                 (d < exp_line.size()) ? exp_line[d] : 1'b1, (d < exp_line.size()) ? 1'b1 : 1'b0);
      else
        $display("FAIL %s: captured %0d cycles, required %0d", name, obs_line.size(), exp_line.size() + 1);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; p_data = '0; data_valid = 1'b0; par_en = 1'b0; par_typ = 1'b0; prescale = 6'd8;
    #3;
    n_tests++;
    if (tx_out !== 1'b1) begin n_fail++; $display("FAIL reset_tx: got %b required 1", tx_out); end
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_tests++;
    if (dbg_state !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d required 0", dbg_state); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    build_frame(8'hA5, 0, 0, 8);
    drive_req(8'hA5, 0, 0, 8, 0);
    capture(exp_line.size() + 1, -1);
    report_frame("basic_a5_p8");
  endtask

  task automatic test_parity();
    logic [DW-1:0] words[2];
    logic          par_exp[2][2];
    int            nb;
    words = '{8'hA5, 8'h07};
    par_exp = '{'{1'b0, 1'b1}, '{1'b1, 1'b0}};
    for (int i = 0; i < 2; i++) begin
      for (int t = 0; t < 2; t++) begin
        build_frame(words[i], 1, t[0], 4);
        drive_req(words[i], 1, t[0], 4, 0);
        capture(exp_line.size() + 1, -1);
        report_frame($sformatf("parity_frame_%02h_typ%0d", words[i], t));
        n_tests++;
        if (obs_line[9 * 4 + 2] !== par_exp[i][t]) begin
          n_fail++;
          $display("FAIL parity_bit_%02h_typ%0d: got %b required %b", words[i], t, obs_line[38], par_exp[i][t]);
        end
        nb = 0;
        foreach (obs_busy[k]) if (obs_busy[k] === 1'b1) nb++;
        n_tests++;
        if (nb != 44) begin n_fail++; $display("FAIL parity_busy_len: got %0d required 44", nb); end
      end
    end
  endtask

  task automatic test_ignore_busy();
    int bad;
    build_frame(8'h00, 0, 0, 8);
    drive_req(8'h00, 0, 0, 8, 0);
    capture(exp_line.size() + 1, 20);
    report_frame("ignore_busy_frame");
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
    end
    n_tests++;
    if (bad != 0) begin n_fail++; $display("FAIL ignore_busy_no_second: %0d non-idle cycles, required 0", bad); end
  endtask

  task automatic test_back_to_back();
    int ps[3];
    int bad;
    ps = '{8, 1, 0};
    foreach (ps[i]) begin
      build_frame(8'h3C, 0, 0, ps[i]);
      drive_req(8'h3C, 0, 0, ps[i], 1);
      #1 p_data = 8'hC3;
      capture(exp_line.size() + 1, -1);
      report_frame($sformatf("b2b_first_p%0d", ps[i]));
      @(posedge clk);
      #1 data_valid = 1'b0;
      build_frame(8'hC3, 0, 0, ps[i]);
      capture(exp_line.size() + 1, -1);
      report_frame($sformatf("b2b_second_p%0d", ps[i]));
      bad = 0;
      for (int k = 0; k < 12; k++) begin
        @(negedge clk);
        if (tx_out !== 1'b1 || busy !== 1'b0) bad++;
      end
      n_tests++;
      if (bad != 0) begin n_fail++; $display("FAIL b2b_no_third_p%0d: %0d non-idle cycles", ps[i], bad); end
    end
  endtask

  task automatic test_reset_mid();
    drive_req(8'h00, 0, 0, 8, 0);
    repeat (36) @(negedge clk);   // cycle 35: inside data bit 3
    n_tests++;
    if (tx_out !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid_pre: tx_out=%b busy=%b required 0/1", tx_out, busy);
    end
    rst = 1'b1;
    #1;
    n_tests++;
    if (tx_out !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_mid_async: tx_out=%b busy=%b required 1/0", tx_out, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    build_frame(8'h5A, 0, 0, 8);
    drive_req(8'h5A, 0, 0, 8, 0);
    capture(exp_line.size() + 1, -1);
    report_frame("reset_mid_recovery");
  endtask

  task automatic test_loopback();
    logic [DW-1:0] w, got, want;
    logic          pe, pt, par_rx, stop_rx, seen;
    int            c, tgt;
    for (int n = 0; n < 256; n++) begin
      w  = DW'($urandom_range(0, 255));
      pe = logic'($urandom_range(0, 1));
      pt = logic'($urandom_range(0, 1));
      exp_q.push_back(w);
      drive_req(w, pe, pt, 8, 0);
      // receiver: find the falling start edge, then sample mid-bit
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        if (tx_out === 1'b0) seen = 1'b1;
      end
      n_tests++;
      if (!seen) begin
        n_fail++; $display("FAIL loopback_start_%0d: no start bit within 20 cycles", n);
        void'(exp_q.pop_front());
        continue;
      end
      c = 0;
      got = '0;
      for (int i = 0; i < DW; i++) begin
        tgt = (1 + i) * 8 + 4;
        repeat (tgt - c) @(negedge clk);
        c = tgt;
        got[i] = tx_out;
      end
      par_rx = 1'b0;
      if (pe) begin
        tgt = (1 + DW) * 8 + 4;
        repeat (tgt - c) @(negedge clk);
        c = tgt;
        par_rx = tx_out;
      end
      tgt = (1 + DW + int'(pe)) * 8 + 4;
      repeat (tgt - c) @(negedge clk);
      stop_rx = tx_out;
      seen = 1'b0;
      for (int t = 0; t < 20 && !seen; t++) begin
        @(negedge clk);
        if (busy === 1'b0) seen = 1'b1;
      end
      want = exp_q.pop_front();
      if (got !== want || stop_rx !== 1'b1 || !seen ||
          (pe && (par_rx !== (logic'(($countones(got) % 2) == 1) ^ pt)))) begin
        n_fail++;
        $display("FAIL loopback_%0d: got %02h par=%b stop=%b idle=%b, required %02h pe=%b pt=%b stop=1",
                 n, got, par_rx, stop_rx, seen, want, pe, pt);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_ignore_busy();
    test_back_to_back();
    test_reset_mid();
    test_loopback();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
